// File: rtl/local_mem_arbiter.sv
// Shares one single-port local memory between load/store (port A, fixed 1-cycle) and
// instruction fetch (port B, 1-entry pending buffer). Define LOCAL_MEM_ARB_STATS_EN for conflict_cnt.
module local_mem_arbiter #(
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_en,
    input  logic [29:0] a_addr,
    input  logic [3:0]  a_be,
    input  logic [31:0] a_data_in,
    output logic [31:0] a_data_out,
    output logic        a_ready,
    input  logic        b_valid,
    input  logic [29:0] b_addr,
    output logic        b_ready,
    input  logic        b_flush,
    output logic [31:0] b_data_out,
    output logic        b_data_valid,
    output logic        mem_en,
    output logic [29:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out,
    output logic [31:0] conflict_cnt
);

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    logic        pend_valid;
    logic [29:0] pend_addr;
    logic        b_inflight;
    logic        b_dv_q;
    logic [7:0]  starve_cnt;
    logic [7:0]  starve_next;
    logic        holdoff;
    logic        b_issue;
    logic        b_accept;

    assign b_issue  = !a_en && pend_valid && !b_flush;
    // A flush empties the buffer, so a fetch presented alongside it is taken as the new target.
    assign b_ready  = !pend_valid || b_issue || b_flush;
    assign b_accept = b_valid && b_ready;
    assign a_ready  = !holdoff;

    always_comb begin
        mem_en      = a_en || b_issue;
        mem_addr    = a_addr;
        mem_be      = a_be;
        mem_data_in = a_data_in;
        if (!a_en) begin
            mem_addr = pend_addr;
            mem_be   = 4'h0;
        end
    end

    assign a_data_out   = mem_data_out;
    assign b_data_valid = b_inflight && b_dv_q && !b_flush;
    assign b_data_out   = b_data_valid ? mem_data_out : 32'h0;

    always_comb begin
        starve_next = starve_cnt;
        if (b_issue || b_flush || holdoff)
            starve_next = 8'h0;
        else if (pend_valid && a_en && starve_cnt != LIMIT)
            starve_next = starve_cnt + 8'h1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_valid <= 1'b0;
            pend_addr  <= '0;
            b_inflight <= 1'b0;
            b_dv_q     <= 1'b0;
            starve_cnt <= 8'h0;
            holdoff    <= 1'b0;
        end else begin
            if (b_accept) begin
                pend_valid <= 1'b1;
                pend_addr  <= b_addr;
            end else if (b_issue || b_flush) begin
                pend_valid <= 1'b0;
            end
            b_inflight <= b_issue;
            b_dv_q     <= b_issue && !b_flush;
            starve_cnt <= starve_next;
            // One-cycle hold-off of A the cycle after the limit is reached.
            holdoff    <= (starve_next == LIMIT);
        end
    end

`ifdef LOCAL_MEM_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            conflict_cnt <= 32'h0;
        else if (pend_valid && a_en && conflict_cnt != 32'hFFFF_FFFF)
            conflict_cnt <= conflict_cnt + 32'h1;
    end
`else
    assign conflict_cnt = 32'h0;
`endif

endmodule
